// File: rtl/grad_central_diff.sv
// -----------------------------------------------------------------------------
// grad_central_diff
//
// Streaming central-difference gradient stage. Pixels arrive one per valid
// cycle in raster order. For every interior pixel it produces
//   Ix = P(x+1,y) - P(x-1,y)   and   Iy = P(x,y+1) - P(x,y-1),
// one clock after the pixel that completes the 3x3 neighbourhood is accepted.
// Two line buffers hold the previous two rows. Short tap registers hold the
// few values that are needed from neighbouring columns. No frame is stored.
//
// Optional feature: define GRAD_MAG_EN to add out_mag = |Ix| + |Iy|.
//
// Ports
//   clk        in   clock, rising edge
//   rstn       in   asynchronous active-low reset
//   pix_valid  in   input pixel qualifier (no backpressure)
//   pix_data   in   unsigned pixel, DATA_WIDTH bits
//   pix_sof    in   with pix_valid: this pixel is (0,0) of a new frame
//   out_valid  out  single-cycle pulse per gradient result
//   out_ix     out  signed DATA_WIDTH+1, horizontal gradient
//   out_iy     out  signed DATA_WIDTH+1, vertical gradient
//   out_x      out  centre column of the result
//   out_y      out  centre row of the result
//   out_eof    out  with out_valid: last interior pixel of the frame
//   out_mag    out  |Ix|+|Iy|, DATA_WIDTH+2 bits (GRAD_MAG_EN only)
// -----------------------------------------------------------------------------
module grad_central_diff #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 16,
  parameter int IMG_H      = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      pix_valid,
  input  logic [DATA_WIDTH-1:0]     pix_data,
  input  logic                      pix_sof,
  output logic                      out_valid,
  output logic [DATA_WIDTH:0]       out_ix,
  output logic [DATA_WIDTH:0]       out_iy,
  output logic [$clog2(IMG_W)-1:0]  out_x,
  output logic [$clog2(IMG_H)-1:0]  out_y,
  output logic                      out_eof
`ifdef GRAD_MAG_EN
  ,
  output logic [DATA_WIDTH+1:0]     out_mag
`endif
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_EOF  = XW'(IMG_W - 2);
  localparam logic [YW-1:0] Y_EOF  = YW'(IMG_H - 2);
  localparam logic [XW-1:0] X_TWO  = XW'(2);
  localparam logic [YW-1:0] Y_TWO  = YW'(2);

  // Raster position of the next pixel to be accepted.
  logic [XW-1:0] cx_q, cx_d;
  logic [YW-1:0] cy_q, cy_d;

  // Line buffers: l1 holds row cy-1, l2 holds row cy-2, both indexed by column.
  logic [DATA_WIDTH-1:0] l1_mem [IMG_W];
  logic [DATA_WIDTH-1:0] l2_mem [IMG_W];

  // Column taps. The row cy-1 value at cx comes straight from l1. The taps
  // give it at cx-1 and cx-2. The current-row and row cy-2 values at cx-1
  // are each one accept old.
  logic [DATA_WIDTH-1:0] r1_tap0_q;  // row cy-1, column cx-1
  logic [DATA_WIDTH-1:0] r1_tap1_q;  // row cy-1, column cx-2
  logic [DATA_WIDTH-1:0] cur_tap_q;  // row cy,   column cx-1
  logic [DATA_WIDTH-1:0] l2_tap_q;   // row cy-2, column cx-1

  // Output registers.
  logic                  out_valid_q;
  logic [DATA_WIDTH:0]   out_ix_q, out_iy_q;
  logic [XW-1:0]         out_x_q;
  logic [YW-1:0]         out_y_q;
  logic                  out_eof_q;

  // Combinational datapath.
  logic [XW-1:0]         acc_x;
  logic [YW-1:0]         acc_y;
  logic [DATA_WIDTH-1:0] r1_at_x;
  logic [DATA_WIDTH-1:0] l2_at_x;
  logic                  interior;
  logic [DATA_WIDTH:0]   ix_d, iy_d;
  logic [XW-1:0]         cen_x;
  logic [YW-1:0]         cen_y;
  logic                  eof_d;

  always_comb begin
    // sof pins this pixel to (0,0). Any partly received frame is dropped,
    // because its rows can no longer reach cy>=2.
    acc_x    = pix_sof ? '0 : cx_q;
    acc_y    = pix_sof ? '0 : cy_q;
    r1_at_x  = l1_mem[acc_x];
    l2_at_x  = l2_mem[acc_x];

    cx_d = cx_q;
    cy_d = cy_q;
    if (pix_valid) begin
      if (acc_x == X_LAST) begin
        cx_d = '0;
        cy_d = (acc_y == Y_LAST) ? '0 : acc_y + YW'(1);
      end else begin
        cx_d = acc_x + XW'(1);
        cy_d = acc_y;
      end
    end

    interior = pix_valid && (acc_x >= X_TWO) && (acc_y >= Y_TWO);

    // Zero-extend both operands before subtracting, so the result is always
    // representable in DATA_WIDTH+1 bits of two's complement.
    ix_d  = {1'b0, r1_at_x}   - {1'b0, r1_tap1_q};
    iy_d  = {1'b0, cur_tap_q} - {1'b0, l2_tap_q};
    cen_x = acc_x - XW'(1);
    cen_y = acc_y - YW'(1);
    eof_d = (cen_x == X_EOF) && (cen_y == Y_EOF);
  end

`ifdef GRAD_MAG_EN
  logic [DATA_WIDTH:0]   abs_ix, abs_iy;
  logic [DATA_WIDTH+1:0] mag_d;
  logic [DATA_WIDTH+1:0] out_mag_q;

  always_comb begin
    // A magnitude is at most 2^DATA_WIDTH-1, so the sum cannot overflow.
    abs_ix = ix_d[DATA_WIDTH] ? -ix_d : ix_d;
    abs_iy = iy_d[DATA_WIDTH] ? -iy_d : iy_d;
    mag_d  = {1'b0, abs_ix} + {1'b0, abs_iy};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_mag_q <= '0;
    end else if (interior) begin
      out_mag_q <= mag_d;
    end
  end

  assign out_mag = out_mag_q;
`endif

  // Counters and output registers. These are the only state visible after
  // reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cx_q        <= '0;
      cy_q        <= '0;
      out_valid_q <= 1'b0;
      out_ix_q    <= '0;
      out_iy_q    <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_eof_q   <= 1'b0;
    end else begin
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      out_valid_q <= interior;
      if (interior) begin
        out_ix_q  <= ix_d;
        out_iy_q  <= iy_d;
        out_x_q   <= cen_x;
        out_y_q   <= cen_y;
        out_eof_q <= eof_d;
      end
    end
  end

  // The line buffers and taps are not reset. Rows 0 and 1 of every frame
  // refill them before any result depends on their contents.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      l1_mem[acc_x] <= pix_data;
      l2_mem[acc_x] <= r1_at_x;
      r1_tap0_q     <= r1_at_x;
      r1_tap1_q     <= r1_tap0_q;
      cur_tap_q     <= pix_data;
      l2_tap_q      <= l2_at_x;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ix    = out_ix_q;
  assign out_iy    = out_iy_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_eof   = out_eof_q;

endmodule

// File: tb/tb_grad_central_diff.sv
module tb_grad_central_diff;

  localparam int DW = 8;
  localparam int W  = 16;
  localparam int H  = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          pix_valid = 1'b0;
  logic [DW-1:0] pix_data = '0;
  logic          pix_sof = 1'b0;
  logic          out_valid;
  logic [DW:0]   out_ix, out_iy;
  logic [3:0]    out_x, out_y;
  logic          out_eof;
`ifdef GRAD_MAG_EN
  logic [DW+1:0] out_mag;
`else
  logic [DW+1:0] out_mag = '0;
`endif

  grad_central_diff #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_sof   (pix_sof),
    .out_valid (out_valid),
    .out_ix    (out_ix),
    .out_iy    (out_iy),
    .out_x     (out_x),
    .out_y     (out_y),
`ifdef GRAD_MAG_EN
    .out_mag   (out_mag),
`endif
    .out_eof   (out_eof)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW:0]   ix;
    logic [DW:0]   iy;
    logic [3:0]    x;
    logic [3:0]    y;
    logic          eof;
    logic [DW+1:0] mag;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   n_results = 0;
  int   n_eof = 0;
  int   n_nonzero = 0;

  logic [DW:0]   last_ix = '0, last_iy = '0;
  logic [3:0]    last_x = '0, last_y = '0;
  logic          last_eof = 1'b0;
  logic [DW+1:0] last_mag = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Image sources: 0 ramp, 1 constant, 2 impulse, 3 mixed pattern
  function automatic logic [DW-1:0] img_pix(int id, int x, int y);
    case (id)
      0:       return 8'((16 * y + x) & 255);
      1:       return 8'd100;
      2:       return (x == 5 && y == 5) ? 8'd255 : 8'd0;
      default: return 8'((x * 7 + y * 13 + 3) & 255);
    endcase
  endfunction

  // Drive one pixel (called just after a rising edge); push its result if interior
  task automatic drive_pixel(int id, int x, int y, logic sof);
    exp_t e;
    int a, b;
    pix_valid = 1'b1;
    pix_data  = img_pix(id, x, y);
    pix_sof   = sof;
    if (x >= 2 && y >= 2) begin
      a     = int'(img_pix(id, x, y - 1)) - int'(img_pix(id, x - 2, y - 1));
      b     = int'(img_pix(id, x - 1, y)) - int'(img_pix(id, x - 1, y - 2));
      e.ix  = 9'(a);
      e.iy  = 9'(b);
      e.x   = 4'(x - 1);
      e.y   = 4'(y - 1);
      e.eof = (x - 1 == W - 2) && (y - 1 == H - 2);
      e.mag = 10'((a < 0 ? -a : a) + (b < 0 ? -b : b));
      e.cyc = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic send_frame(int id, int start_idx, int n, bit sof_first, bit gaps);
    for (int i = 0; i < n; i++) begin
      drive_pixel(id, (start_idx + i) % W, (start_idx + i) / W, sof_first && (i == 0));
      if (gaps) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic drain(string name);
    int k = 0;
    while (sb.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: outstanding=%0d required=0", name, sb.size());
    end
    @(posedge clk); #1;
  endtask

  // Scoreboard / output monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      last_ix = '0; last_iy = '0; last_x = '0; last_y = '0; last_eof = 1'b0; last_mag = '0;
    end else if (out_valid === 1'b1) begin
      n_results++;
      if (out_eof === 1'b1) n_eof++;
      if (out_ix !== '0 || out_iy !== '0) n_nonzero++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got x=%0d y=%0d ix=%0d iy=%0d at cyc %0d, required no result",
                 out_x, out_y, $signed(out_ix), $signed(out_iy), cyc);
      end else begin
        e = sb.pop_front();
        if (out_ix !== e.ix || out_iy !== e.iy || out_x !== e.x || out_y !== e.y ||
            out_eof !== e.eof || cyc != e.cyc
`ifdef GRAD_MAG_EN
            || out_mag !== e.mag
`endif
           ) begin
          errors++;
          $display("FAIL result: got x=%0d y=%0d ix=%0d iy=%0d eof=%0b mag=%0d cyc=%0d, required x=%0d y=%0d ix=%0d iy=%0d eof=%0b mag=%0d cyc=%0d",
                   out_x, out_y, $signed(out_ix), $signed(out_iy), out_eof, out_mag, cyc,
                   e.x, e.y, $signed(e.ix), $signed(e.iy), e.eof, e.mag, e.cyc);
        end
      end
      last_ix = out_ix; last_iy = out_iy; last_x = out_x; last_y = out_y;
      last_eof = out_eof; last_mag = out_mag;
    end else begin
      checks++;
      if ({out_ix, out_iy, out_x, out_y, out_eof, out_mag} !==
          {last_ix, last_iy, last_x, last_y, last_eof, last_mag}) begin
        errors++;
        $display("FAIL hold: got x=%0d y=%0d ix=%0d iy=%0d eof=%0b, required x=%0d y=%0d ix=%0d iy=%0d eof=%0b",
                 out_x, out_y, $signed(out_ix), $signed(out_iy), out_eof,
                 last_x, last_y, $signed(last_ix), $signed(last_iy), last_eof);
      end
    end
  end

  task automatic check_count(string name, int got, int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  task automatic check_outputs_zero(string name);
    checks++;
    if ({out_valid, out_ix, out_iy, out_x, out_y, out_eof, out_mag} !== '0) begin
      errors++;
      $display("FAIL %s: got valid=%0b ix=%0d iy=%0d x=%0d y=%0d eof=%0b mag=%0d, required all 0",
               name, out_valid, out_ix, out_iy, out_x, out_y, out_eof, out_mag);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_outputs");
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    $display("test_reset done");
  endtask

  task automatic test_ramp();
    int n0 = n_results, e0 = n_eof;
    send_frame(0, 0, W * H, 1'b1, 1'b0);
    drain("ramp");
    check_count("ramp_results", n_results - n0, 196);
    check_count("ramp_eof", n_eof - e0, 1);
    $display("test_ramp done");
  endtask

  task automatic test_const();
    int n0 = n_results, z0 = n_nonzero;
    send_frame(1, 0, W * H, 1'b1, 1'b0);
    drain("const");
    check_count("const_results", n_results - n0, 196);
    check_count("const_nonzero", n_nonzero - z0, 0);
    $display("test_const done");
  endtask

  task automatic test_impulse();
    int n0 = n_results, z0 = n_nonzero;
    send_frame(2, 0, W * H, 1'b1, 1'b0);
    drain("impulse");
    check_count("impulse_results", n_results - n0, 196);
    check_count("impulse_nonzero", n_nonzero - z0, 4);
    $display("test_impulse done");
  endtask

  task automatic test_gaps();
    int n0 = n_results, e0 = n_eof;
    send_frame(0, 0, W * H, 1'b1, 1'b1);
    drain("gaps");
    check_count("gaps_results", n_results - n0, 196);
    check_count("gaps_eof", n_eof - e0, 1);
    $display("test_gaps done");
  endtask

  task automatic test_reset_midframe();
    int n0 = n_results;
    send_frame(0, 0, 9 * W + 7, 1'b1, 1'b0);  // up to (6,9)
    drain("pre_reset");
    check_count("pre_reset_results", n_results - n0, 103);
    // Pixel (7,9) is on the bus while reset is asserted
    pix_valid = 1'b1;
    pix_data  = img_pix(0, 7, 9);
    rstn      = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_outputs_zero("midframe_reset_outputs");
    end
    @(posedge clk); #1;
    rstn      = 1'b1;
    pix_valid = 1'b0;
    n0 = n_results;
    send_frame(0, 0, W * H, 1'b0, 1'b0);       // fresh frame, no sof
    send_frame(3, 0, 4 * W + 3, 1'b0, 1'b0);   // cut short before (3,4)
    send_frame(0, 0, W * H, 1'b1, 1'b0);       // sof lands at (3,4)
    drain("post_reset");
    check_count("post_reset_results", n_results - n0, 196 + 29 + 196);
    $display("test_reset_midframe done");
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_ramp();
    test_const();
    test_impulse();
    test_gaps();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/grad_central_diff.md
Name: grad_central_diff

Overview:
- Streaming spatial-gradient stage directly downstream of the gray-stretch frame buffer.
- Consumes its stretched pixel stream (one pixel per valid cycle, raster order).
- Produces central-difference gradients Ix, Iy for every interior pixel, which feed the flow-estimation core.
- Holds two line buffers plus column taps; no frame storage.

Parameters:
- DATA_WIDTH, 8, pixel width (unsigned).
- IMG_W, 16, pixels per line; must be ≥3.
- IMG_H, 16, lines per frame; must be ≥3. IMG_W*IMG_H matches the upstream frame size.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- pix_valid  in  1  input pixel qualifier; no backpressure.
- pix_data  in  DATA_WIDTH  stretched pixel.
- pix_sof  in  1  with pix_valid: this pixel is (0,0) of a new frame.
- out_valid  out  1  gradient outputs valid this cycle.
- out_ix  out  DATA_WIDTH+1  signed, P(x+1,y) − P(x−1,y).
- out_iy  out  DATA_WIDTH+1  signed, P(x,y+1) − P(x,y−1).
- out_x  out  clog2(IMG_W)  centre column.
- out_y  out  clog2(IMG_H)  centre row.
- out_eof  out  1  with out_valid: last interior pixel, (IMG_W−2, IMG_H−2).
- out_mag  out  DATA_WIDTH+2  present only with GRAD_MAG_EN.

Behaviour:
- Reset: all outputs 0. Column/row counters 0. Line buffers and column taps are not cleared; their stale contents are never observable.
- Counters advance only on pix_valid.
  - pix_valid=0 cycles are gaps: all state holds and out_valid=0.
- Coordinates and wrap:
  - Accepted pixel takes coordinate (cx,cy).
  - cx wraps IMG_W−1→0 and increments cy.
  - cy wraps IMG_H−1→0 (free-running; matches the wrapping upstream address).
- pix_sof with pix_valid forces this pixel to (0,0) regardless of counter state.
  - A frame cut short by sof is abandoned: no further outputs for it.
  - The sof pixel itself produces no output.
- Storage:
  - Line buffer L1 holds row cy−1; L2 holds row cy−2.
  - Each is written at index cx on accept.
  - Three-tap column shift registers hold row cy−1 at cx, cx−1, cx−2.
- Output rule: accepting pixel (cx,cy) with cx≥2 and cy≥2 produces a result for centre (cx−1, cy−1):
  - Ix = R1[cx] − R1[cx−2].
  - Iy = P(cx−1,cy) − L2[cx−1]. The current-row tap at cx−1 is used, not the incoming pixel.
- Output timing:
  - Registered, latency exactly 1 clock after the accepting edge.
  - out_valid is a single-cycle pulse per result.
  - Outputs other than out_valid hold their last value when out_valid=0.
- Border pixels (row 0, row IMG_H−1, column 0, column IMG_W−1) produce no output.
  - Results per frame = (IMG_W−2)(IMG_H−2); 196 for 16×16.
- Arithmetic: zero-extend operands to DATA_WIDTH+1, then subtract two's-complement. Range ±(2^DATA_WIDTH−1); no overflow possible.
- out_eof = 1 exactly when out_x = IMG_W−2 and out_y = IMG_H−2.
- Reset mid-frame:
  - The next accepted pixel is (0,0) even without sof.
  - No output until cy≥2 of that frame.

Optional Feature:
- Macro GRAD_MAG_EN.
- Defined:
  - Port out_mag is added.
  - out_mag = |Ix| + |Iy|, unsigned DATA_WIDTH+2 bits, no saturation (max 510 at 8 bits).
  - Registered in the same cycle as out_ix/out_iy; reset 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Ramp P=16y+x, 16×16, continuous valid with sof on first pixel:
  - 196 out_valid pulses, all out_ix=2 and out_iy=32.
  - First result is centre (1,1), one clock after accepting pixel (2,2).
  - out_eof only at (14,14).
- Constant frame P=100: 196 results, all out_ix=0, out_iy=0.
- Impulse: P(5,5)=255, rest 0:
  - (4,5): Ix=+255.
  - (6,5): Ix=−255.
  - (5,4): Iy=+255.
  - (5,6): Iy=−255.
  - All other results zero.
- Ramp frame with pix_valid toggled 1/0 every cycle: identical result sequence to continuous valid, out_valid never asserted in gap-following cycles without a new accept.
- rstn low for 2 cycles mid-frame at pixel (7,9), then a fresh ramp frame without sof:
  - Outputs 0 during reset.
  - The full 196-result sequence is correct.
  - The second frame is sent with sof mid-frame at (3,4); the abandoned frame yields no further results.
- With GRAD_MAG_EN, impulse frame: out_mag=255 at (4,5), (6,5), (5,4), (5,6); 0 elsewhere.
